// File: rtl/phy_tx_lane_sched.sv
// PHY transmit lane scheduler: captures a 4-lane byte group and serializes it
// onto one byte stream, lane 0 first, with ready/valid on both sides.
module phy_tx_lane_sched #(
    parameter bit          SKIP_INVALID = 1'b1,
    parameter logic [7:0]  IDLE_BYTE    = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1,
    input  logic [7:0]  in2,
    input  logic [7:0]  in3,
    input  logic        valid0,
    input  logic        valid1,
    input  logic        valid2,
    input  logic        valid3,
    output logic        in_ready,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        out_ready,
    output logic [1:0]  lane_id,
    output logic        err_overrun,
    output logic [15:0] groups_sent
);

    localparam int unsigned W     = 8;
    localparam int unsigned LANES = 4;
    localparam int unsigned CW    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                      r_state;
    logic [LANES-1:0][W-1:0]     r_buf;
    logic [LANES-1:0]            r_pend;
    logic [LANES-1:0]            r_vmask;
    logic                        r_err;
    logic [CW-1:0]               r_cnt;

    logic [LANES-1:0]            w_valid;
    logic [LANES-1:0]            w_cur_oh;
    logic [1:0]                  w_cur;
    logic                        w_found;
    logic                        w_present;
    logic                        w_xfer;
    logic                        w_last;
    logic                        w_in_ready;
    logic                        w_cap;
    logic [W-1:0]                w_byte;

    // Lowest pending lane is the one currently on the output.
    always_comb begin
        w_cur   = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (r_pend[i] && !w_found) begin
                w_cur   = 2'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_valid    = {valid3, valid2, valid1, valid0};
        w_present  = |w_valid;
        w_cur_oh   = LANES'(1) << w_cur;
        w_last     = (r_pend & ~w_cur_oh) == '0;
        w_xfer     = (r_state == ST_SEND) && out_ready;
        w_in_ready = !reset && ((r_state == ST_IDLE) || (w_xfer && w_last));
        w_cap      = w_in_ready && w_present;
        w_byte     = (!SKIP_INVALID && !r_vmask[w_cur]) ? IDLE_BYTE : r_buf[w_cur];
    end

    // A capture on the last beat overrides the return to IDLE, giving back-to-back groups.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_buf   <= '0;
            r_pend  <= '0;
            r_vmask <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_err <= w_present && !w_in_ready;
            if (w_xfer) begin
                r_pend <= r_pend & ~w_cur_oh;
                if (w_last) begin
                    r_cnt   <= r_cnt + CW'(1);
                    r_state <= ST_IDLE;
                end
            end
            if (w_cap) begin
                r_buf   <= {in3, in2, in1, in0};
                r_pend  <= SKIP_INVALID ? w_valid : '1;
                r_vmask <= w_valid;
                r_state <= ST_SEND;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign valid_out   = (r_state == ST_SEND);
    assign data_out    = valid_out ? w_byte : '0;
    assign lane_id     = valid_out ? w_cur : '0;
    assign err_overrun = r_err;
    assign groups_sent = r_cnt;

endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Scoreboard bench for phy_tx_lane_sched: one skipping and one padding instance,
// each driven independently and checked against a beat-list reference model.
module tb_phy_tx_lane_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [7:0]  in_d   [2][4];
    logic [3:0]  v_in   [2];
    logic        o_rdy  [2];
    logic        in_rdy [2];
    logic [7:0]  dout   [2];
    logic        vout   [2];
    logic [1:0]  lid    [2];
    logic        err    [2];
    logic [15:0] gsent  [2];

    phy_tx_lane_sched #(.SKIP_INVALID(1'b1), .IDLE_BYTE(8'h00)) u_skip (
        .clk(clk), .reset(reset),
        .in0(in_d[0][0]), .in1(in_d[0][1]), .in2(in_d[0][2]), .in3(in_d[0][3]),
        .valid0(v_in[0][0]), .valid1(v_in[0][1]), .valid2(v_in[0][2]), .valid3(v_in[0][3]),
        .in_ready(in_rdy[0]), .data_out(dout[0]), .valid_out(vout[0]), .out_ready(o_rdy[0]),
        .lane_id(lid[0]), .err_overrun(err[0]), .groups_sent(gsent[0])
    );

    phy_tx_lane_sched #(.SKIP_INVALID(1'b0), .IDLE_BYTE(8'h00)) u_pad (
        .clk(clk), .reset(reset),
        .in0(in_d[1][0]), .in1(in_d[1][1]), .in2(in_d[1][2]), .in3(in_d[1][3]),
        .valid0(v_in[1][0]), .valid1(v_in[1][1]), .valid2(v_in[1][2]), .valid3(v_in[1][3]),
        .in_ready(in_rdy[1]), .data_out(dout[1]), .valid_out(vout[1]), .out_ready(o_rdy[1]),
        .lane_id(lid[1]), .err_overrun(err[1]), .groups_sent(gsent[1])
    );

    typedef struct {
        logic [7:0] d;
        logic [1:0] lane;
    } beat_t;

    typedef struct {
        int         tag;
        logic       err;
        logic [15:0] cnt;
        logic       busy;
        logic       rst;
    } stat_t;

    beat_t exp_q [2][$];
    stat_t st_q  [2][$];

    int checks   = 0;
    int failures = 0;
    int ecount   = 0;

    // Reference model state: beats still owed per instance and groups completed.
    int          rem     [2];
    logic [15:0] mcnt    [2];
    logic [7:0]  g_d     [2][4];
    logic [3:0]  g_v     [2];
    int          pol     [2];
    logic        rdy_set [2];
    logic        ir_exp  [2];

    always @(posedge clk) ecount++;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, k, $time, act, req);
        end
    endtask

    task automatic set_grp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [3:0] v, input int p);
        for (int k = 0; k < 2; k++) begin
            g_d[k][0] = a; g_d[k][1] = b; g_d[k][2] = c; g_d[k][3] = d;
            g_v[k] = v;
            pol[k] = p;
        end
    endtask

    task automatic set_rdy(input logic r);
        rdy_set[0] = r;
        rdy_set[1] = r;
    endtask

    // pol: 0 = present nothing, 1 = present every cycle, 2 = present only while ready, once.
    task automatic step(input logic rst_v);
        @(posedge clk);
        #1;
        reset = rst_v;
        for (int k = 0; k < 2; k++) begin
            logic busy, xfer, last, ir, pres, e;
            int   n;
            beat_t bt;
            busy = rem[k] > 0;
            xfer = busy && rdy_set[k];
            last = xfer && (rem[k] == 1);
            ir   = !rst_v && (!busy || last);
            pres = (pol[k] == 1) || (pol[k] == 2 && ir);
            for (int i = 0; i < 4; i++) in_d[k][i] = g_d[k][i];
            v_in[k]  = pres ? g_v[k] : 4'b0000;
            o_rdy[k] = rdy_set[k];
            pres = pres && (g_v[k] != 4'b0000);
            e = 1'b0;
            if (rst_v) begin
                rem[k]  = 0;
                mcnt[k] = '0;
                exp_q[k].delete();
            end else begin
                if (xfer) rem[k]--;
                if (last) mcnt[k]++;
                if (pres && ir) begin
                    n = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (k == 1 || g_v[k][i]) begin
                            bt.d    = g_v[k][i] ? g_d[k][i] : 8'h00;
                            bt.lane = 2'(i);
                            exp_q[k].push_back(bt);
                            n++;
                        end
                    end
                    rem[k] = n;
                    if (pol[k] == 2) pol[k] = 0;
                end
                e = pres && !ir;
            end
            ir_exp[k] = ir;
            st_q[k].push_back('{ecount + 1, e, mcnt[k], rem[k] > 0, rst_v});
        end
        #1;
        for (int k = 0; k < 2; k++) chk("in_ready", k, 32'(in_rdy[k]), 32'(ir_exp[k]));
    endtask

    // Monitor: per-edge status plus the beat stream, popped on each accepted beat.
    always @(negedge clk) begin
        stat_t s;
        beat_t b;
        for (int k = 0; k < 2; k++) begin
            while (st_q[k].size() > 0 && st_q[k][0].tag < ecount) void'(st_q[k].pop_front());
            if (st_q[k].size() > 0 && st_q[k][0].tag == ecount) begin
                s = st_q[k].pop_front();
                chk("valid_out", k, 32'(vout[k]), 32'(s.busy));
                chk("err_overrun", k, 32'(err[k]), 32'(s.err));
                chk("groups_sent", k, 32'(gsent[k]), 32'(s.cnt));
                if (s.rst) begin
                    chk("reset_data", k, 32'(dout[k]), 32'h0);
                    chk("reset_lane", k, 32'(lid[k]), 32'h0);
                end
            end
            if (!reset && vout[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    chk("unexpected_beat", k, 32'h1, 32'h0);
                end else begin
                    b = exp_q[k][0];
                    chk("data_out", k, 32'(dout[k]), 32'(b.d));
                    chk("lane_id", k, 32'(lid[k]), 32'(b.lane));
                    if (o_rdy[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                in_d[k][i] = 8'h00;
                g_d[k][i]  = 8'h00;
            end
            v_in[k]    = 4'b0000;
            g_v[k]     = 4'b0000;
            o_rdy[k]   = 1'b1;
            rdy_set[k] = 1'b1;
            rem[k]     = 0;
            mcnt[k]    = '0;
            pol[k]     = 0;
        end

        repeat (3) step(1'b1);
        step(1'b0);

        // Single full group.
        set_grp(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'hF, 2);
        repeat (8) step(1'b0);

        // Back-to-back groups, second captured on the last beat of the first.
        set_grp(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'hF, 2);
        step(1'b0);
        set_grp(8'hBB, 8'hAA, 8'h99, 8'h88, 4'hF, 2);
        repeat (10) step(1'b0);

        // Only lane 2 valid.
        set_grp(8'h11, 8'h22, 8'h77, 8'h33, 4'b0100, 2);
        repeat (7) step(1'b0);

        // Backpressure on the second beat with an overrunning group during the hold.
        set_grp(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'hF, 2);
        set_rdy(1'b1);
        step(1'b0);
        step(1'b0);
        set_rdy(1'b0);
        step(1'b0);
        set_grp(8'h55, 8'h66, 8'h77, 8'h88, 4'hF, 1);
        step(1'b0);
        set_grp(8'h55, 8'h66, 8'h77, 8'h88, 4'hF, 0);
        step(1'b0);
        set_rdy(1'b1);
        repeat (6) step(1'b0);

        // Reset after two beats of a group.
        set_grp(8'hFF, 8'hEE, 8'hDD, 8'hCC, 4'hF, 2);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        step(1'b1);
        repeat (5) step(1'b0);

        // Randomized traffic with random backpressure, partial valids and rare resets.
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) g_d[k][i] = 8'($urandom);
                g_v[k]     = 4'($urandom_range(0, 15));
                pol[k]     = int'($urandom_range(0, 2));
                rdy_set[k] = ($urandom_range(0, 9) < 7);
            end
            step($urandom_range(0, 99) == 0);
        end

        for (int k = 0; k < 2; k++) pol[k] = 0;
        set_rdy(1'b1);
        repeat (8) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
